// File: rtl/sequenciador_disco_pkg.sv
// Shared types for the disk-transfer sequencer: FSM state encoding.
package sequenciador_disco_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/sequenciador_disco_if.sv
// Disk controller bus between the sequencer (master) and the disk controller (slave).
// Handshake: disk_req is a one-cycle strobe with disk_we/disk_addr/disk_wdata held stable
// until completion; disk_ack is a one-cycle completion pulse, disk_rdata valid with it.
interface disk_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              disk_req;
  logic              disk_we;
  logic [ADDR_W-1:0] disk_addr;
  logic [DATA_W-1:0] disk_wdata;
  logic              disk_ack;
  logic [DATA_W-1:0] disk_rdata;

  modport master (
    output disk_req, disk_we, disk_addr, disk_wdata,
    input  disk_ack, disk_rdata
  );

  modport slave (
    input  disk_req, disk_we, disk_addr, disk_wdata,
    output disk_ack, disk_rdata
  );
endinterface

// File: rtl/sequenciador_disco_contador_timeout.sv
// Timeout counter for the disk wait phase: clear, count-enable, expiry flag.
module contador_timeout #(
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/sequenciador_disco.sv
// Multi-cycle sequencer for ldk/sdk: stalls the core while one word crosses the slow
// req/ack disk interface, returns read data and flags timeouts.
module sequenciador_disco
  import sequenciador_disco_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              isDisk,
  input  logic              diskWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output state_t            state_dbg,
  disk_if.master            disk
);

  state_t           state, state_nx;
  logic             start;
  logic             cnt_clr, cnt_en, cnt_expired;
  logic [CNT_W-1:0] cnt;

  assign start     = isDisk | diskWrite;
  assign state_dbg = state;

  // Counter is held at zero in IDLE and counts REQ plus every WAIT cycle,
  // so it reads k during the k-th WAIT cycle.
  contador_timeout #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .count  (cnt),
    .expired(cnt_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    stall         = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    disk.disk_req = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        // Combinational stall keeps the PC on the ldk/sdk in its first cycle.
        if (start) begin
          stall    = 1'b1;
          state_nx = ST_REQ;
        end
      end
      ST_REQ: begin
        stall         = 1'b1;
        disk.disk_req = 1'b1;
        cnt_en        = 1'b1;
        state_nx      = disk.disk_ack ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        if (disk.disk_ack) begin
          state_nx = ST_DONE;
        end else if (cnt_expired) begin
          state_nx = ST_ERR;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_ERR: begin
        err      = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata           <= '0;
      disk.disk_we    <= 1'b0;
      disk.disk_addr  <= '0;
      disk.disk_wdata <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        disk.disk_we    <= diskWrite;
        disk.disk_addr  <= addr;
        disk.disk_wdata <= wdata;
      end
      if ((state == ST_REQ || state == ST_WAIT) && disk.disk_ack && !disk.disk_we) begin
        rdata <= disk.disk_rdata;
      end else if (state_nx == ST_ERR) begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sequenciador_disco.sv
// Bench for sequenciador_disco: directed scenarios plus randomized transfers against a
// transaction-level model of latency, timeout and returned data.
module tb_sequenciador_disco;
  import sequenciador_disco_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              isDisk, diskWrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              stall, done, err;
  logic [DATA_W-1:0] rdata;
  state_t            state_dbg;

  disk_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif ();

  sequenciador_disco #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .isDisk   (isDisk),
    .diskWrite(diskWrite),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .state_dbg(state_dbg),
    .disk     (dif.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] model_rdata;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle, optionally with a stray ack carrying junk data.
  task automatic idle_cycle(input bit stray);
    isDisk         = 1'b0;
    diskWrite      = 1'b0;
    dif.disk_ack   = stray;
    dif.disk_rdata = $urandom;
    @(negedge clk);
    check("idle_stall", stall, 0);
    check("idle_done", done, 0);
    check("idle_err", err, 0);
    check("idle_req", dif.disk_req, 0);
    check("idle_rdata", rdata, model_rdata);
    next_cycle();
    dif.disk_ack = 1'b0;
  endtask

  // One transfer. d = cycles from REQ to ack (0 = ack in REQ); d > TIMEOUT means no ack.
  // Model: success finishes d+2 cycles after start, timeout finishes TIMEOUT+2 after start.
  task automatic run_op(input bit wr, input bit both, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input int d, input logic [DATA_W-1:0] rd);
    bit ok;
    int fin;
    bit exp_we;
    ok     = (d <= TIMEOUT);
    fin    = ok ? d + 2 : TIMEOUT + 2;
    exp_we = wr | both;
    if (ok && !exp_we) exp_q.push_back(rd);
    else if (!ok) exp_q.push_back('0);
    else exp_q.push_back(model_rdata);

    isDisk       = both | ~wr;
    diskWrite    = wr | both;
    addr         = a;
    wdata        = wd;
    dif.disk_ack = 1'b0;
    @(negedge clk);
    check("start_stall", stall, 1);
    check("start_req", dif.disk_req, 0);
    next_cycle();
    isDisk    = 1'b0;
    diskWrite = 1'b0;
    addr      = ADDR_W'($urandom);
    wdata     = $urandom;
    for (int t = 1; t <= fin; t++) begin
      dif.disk_ack   = ok && (t == d + 1);
      dif.disk_rdata = dif.disk_ack ? rd : $urandom;
      @(negedge clk);
      if (t < fin) begin
        check("busy_stall", stall, 1);
        check("busy_done", done | err, 0);
        check("busy_req", dif.disk_req, (t == 1));
        check("busy_we", dif.disk_we, exp_we);
        check("busy_addr", dif.disk_addr, a);
        check("busy_wdata", dif.disk_wdata, wd);
      end else begin
        model_rdata = exp_q.pop_front();
        check("end_stall", stall, 0);
        check("end_done", done, ok);
        check("end_err", err, !ok);
        check("end_req", dif.disk_req, 0);
        check("end_rdata", rdata, model_rdata);
      end
      next_cycle();
      dif.disk_ack = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; isDisk = 1'b0; diskWrite = 1'b0; addr = '0; wdata = '0;
    dif.disk_ack = 1'b0; dif.disk_rdata = '0;
    model_rdata = '0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_stall", stall, 0);
    check("rst_outs", {done, err, dif.disk_req, dif.disk_we}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", dif.disk_addr, 0);
    check("rst_wdata", dif.disk_wdata, 0);
    next_cycle();
    rst = 1'b0;
    idle_cycle(0);

    // read, ack 5 cycles after REQ
    run_op(0, 0, 16'h0010, 32'h0, 5, 32'hDEADBEEF);
    // write, ack in REQ
    run_op(1, 0, 16'h0042, 32'h12345678, 0, 32'hAAAA5555);
    idle_cycle(0);
    // timeout, no ack
    run_op(0, 0, 16'h0100, 32'h0, TIMEOUT + 1, 32'h0);
    // ack and expiry coincide
    run_op(0, 0, 16'h0200, 32'h0, TIMEOUT, 32'hCAFEF00D);

    // reset during WAIT
    isDisk = 1'b1; addr = 16'h0300;
    next_cycle();
    isDisk = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("wait_before_rst", state_dbg, ST_WAIT);
    next_cycle();
    rst = 1'b0;
    model_rdata = '0;
    @(negedge clk);
    check("post_rst_state", state_dbg, ST_IDLE);
    check("post_rst_outs", {stall, done, err, dif.disk_req}, 0);
    check("post_rst_addr", dif.disk_addr, 0);
    next_cycle();
    idle_cycle(1);
    idle_cycle(0);

    // back-to-back read then write, stray ack, both strobes high
    run_op(0, 0, 16'h0400, 32'h0, 1, 32'h0BADC0DE);
    run_op(1, 0, 16'h0401, 32'h11112222, 2, 32'h0);
    idle_cycle(1);
    run_op(0, 1, 16'h0402, 32'h33334444, 1, 32'h55556666);

    // randomized transfers
    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(0, 1), $urandom_range(0, 7) == 0, ADDR_W'($urandom), $urandom,
             $urandom_range(0, TIMEOUT + 2), $urandom);
      if ($urandom_range(0, 1) == 1) idle_cycle($urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
